seq_core_mc: RTL and testbench

Multi-cycle successor of the sequential RISC core: same 16-bit instruction set, generalised data-memory interface with a `mem_ready` handshake for variable-latency memories, signed conditional branches, and PC-relative signed jumps. Sits between program memory (combinational fetch on `pc`/`instruction`) and a data memory or bus bridge that may stall. Clocked by `clk`, synchronous active-low `rst`.

---
 rtl/seq_core_mc.sv | 179 +++++++++++++++++
 tb/tb_seq_core_mc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_core_mc.sv
// seq_core_mc: multi-cycle 16-bit-ISA RISC core with a mem_ready data-memory handshake.
// Define SEQ_CORE_MC_MUL_EN to decode opcode 0011100 as an unsigned MUL.
module seq_core_mc #(
    parameter int A_SIZE = 10,
    parameter int D_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [A_SIZE-1:0] pc,
    input  logic [15:0]       instruction,
    output logic              read,
    output logic              write,
    output logic [A_SIZE-1:0] address,
    output logic [D_SIZE-1:0] data_out,
    input  logic [D_SIZE-1:0] data_in,
    input  logic              mem_ready,
    output logic              halted
);
    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] MEM  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    localparam logic [6:0] OP_ADD     = 7'b0000001;
    localparam logic [6:0] OP_ADDF    = 7'b0000010;
    localparam logic [6:0] OP_SUB     = 7'b0000011;
    localparam logic [6:0] OP_SUBF    = 7'b0000100;
    localparam logic [6:0] OP_AND     = 7'b0000101;
    localparam logic [6:0] OP_OR      = 7'b0000110;
    localparam logic [6:0] OP_XOR     = 7'b0000111;
    localparam logic [6:0] OP_NAND    = 7'b0001000;
    localparam logic [6:0] OP_NOR     = 7'b0001001;
    localparam logic [6:0] OP_NXOR    = 7'b0001010;
    localparam logic [6:0] OP_SHIFTR  = 7'b0001011;
    localparam logic [6:0] OP_SHIFTRA = 7'b0001100;
    localparam logic [6:0] OP_SHIFTL  = 7'b0001101;
    localparam logic [6:0] OP_SHIFTLA = 7'b0001110;
    localparam logic [6:0] OP_HALT    = 7'b0001111;
    localparam logic [6:0] OP_MUL     = 7'b0011100;
    localparam logic [4:0] OP_LOAD    = 5'b00100;
    localparam logic [4:0] OP_LOADC   = 5'b00101;
    localparam logic [4:0] OP_STORE   = 5'b00110;
    localparam logic [3:0] OP_JMP     = 4'b1000;
    localparam logic [3:0] OP_JMPC    = 4'b1010;
    localparam logic [3:0] OP_JMPR    = 4'b1100;
    localparam logic [3:0] OP_JMPRC   = 4'b1110;

    localparam logic [2:0] C_N  = 3'd0;
    localparam logic [2:0] C_NN = 3'd1;
    localparam logic [2:0] C_Z  = 3'd2;
    localparam logic [2:0] C_NZ = 3'd3;

    logic [1:0]        state;
    logic [D_SIZE-1:0] regs [8];
    logic [2:0]        dst;
    logic [D_SIZE-1:0] op_a, op_b, op_d, alu_res, mul_res, shr, sra, shl;
    logic              alu_we, mul_en, cond_ok, sh_big;
    logic              is_load, is_store, is_loadc, is_halt;
    logic [A_SIZE-1:0] pc_inc, pc_rel, pc_next;

    // Register values wider or narrower than the address bus map to their low A_SIZE bits.
    function automatic logic [A_SIZE-1:0] to_addr(input logic [D_SIZE-1:0] v);
        logic [A_SIZE+D_SIZE-1:0] w;
        w = {{A_SIZE{1'b0}}, v};
        return w[A_SIZE-1:0];
    endfunction

    assign op_a     = regs[instruction[5:3]];
    assign op_b     = regs[instruction[2:0]];
    assign op_d     = regs[instruction[8:6]];
    assign is_load  = instruction[15:11] == OP_LOAD;
    assign is_store = instruction[15:11] == OP_STORE;
    assign is_loadc = instruction[15:11] == OP_LOADC;
    assign is_halt  = instruction[15:9] == OP_HALT;
    assign halted   = state == HALT;
    assign pc_inc   = pc + 1'b1;
    assign pc_rel   = pc + {{(A_SIZE-6){instruction[5]}}, instruction[5:0]};

    assign sh_big = 32'(instruction[5:0]) >= 32'(D_SIZE);
    assign shr    = sh_big ? '0 : op_d >> instruction[5:0];
    assign sra    = sh_big ? {D_SIZE{op_d[D_SIZE-1]}} : D_SIZE'($signed(op_d) >>> instruction[5:0]);
    assign shl    = sh_big ? '0 : op_d << instruction[5:0];

`ifdef SEQ_CORE_MC_MUL_EN
    assign mul_res = op_a * op_b;
    assign mul_en  = 1'b1;
`else
    assign mul_res = '0;
    assign mul_en  = 1'b0;
`endif

    always_comb begin
        alu_we  = 1'b1;
        alu_res = '0;
        case (instruction[15:9])
            OP_ADD, OP_ADDF:       alu_res = op_a + op_b;
            OP_SUB, OP_SUBF:       alu_res = op_a - op_b;
            OP_AND:                alu_res = op_a & op_b;
            OP_OR:                 alu_res = op_a | op_b;
            OP_XOR:                alu_res = op_a ^ op_b;
            OP_NAND:               alu_res = ~(op_a & op_b);
            OP_NOR:                alu_res = ~(op_a | op_b);
            OP_NXOR:               alu_res = ~(op_a ^ op_b);
            OP_SHIFTR:             alu_res = shr;
            OP_SHIFTRA:            alu_res = sra;
            OP_SHIFTL, OP_SHIFTLA: alu_res = shl;
            OP_MUL: begin
                alu_we  = mul_en;
                alu_res = mul_res;
            end
            default:               alu_we = 1'b0;
        endcase
    end

    always_comb begin
        case (instruction[11:9])
            C_N:     cond_ok = op_d[D_SIZE-1];
            C_NN:    cond_ok = !op_d[D_SIZE-1];
            C_Z:     cond_ok = op_d == '0;
            C_NZ:    cond_ok = op_d != '0;
            default: cond_ok = 1'b0;
        endcase
    end

    // Memory ops and HALT hold pc; it advances when the memory transaction completes.
    always_comb begin
        pc_next = pc_inc;
        if (is_load || is_store || is_halt)
            pc_next = pc;
        else if (instruction[15:12] == OP_JMP || (instruction[15:12] == OP_JMPC && cond_ok))
            pc_next = to_addr(op_b);
        else if (instruction[15:12] == OP_JMPR || (instruction[15:12] == OP_JMPRC && cond_ok))
            pc_next = pc_rel;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            pc       <= '0;
            read     <= 1'b0;
            write    <= 1'b0;
            address  <= '0;
            data_out <= '0;
            dst      <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            case (state)
                RUN: begin
                    pc <= pc_next;
                    if (alu_we) regs[instruction[8:6]] <= alu_res;
                    if (is_loadc) regs[instruction[10:8]][7:0] <= instruction[7:0];
                    if (is_load) begin
                        state   <= MEM;
                        read    <= 1'b1;
                        dst     <= instruction[10:8];
                        address <= to_addr(op_b);
                    end
                    if (is_store) begin
                        state    <= MEM;
                        write    <= 1'b1;
                        address  <= to_addr(regs[instruction[10:8]]);
                        data_out <= op_b;
                    end
                    if (is_halt) state <= HALT;
                end
                MEM: begin
                    if (mem_ready) begin
                        if (read) regs[dst] <= data_in;
                        read  <= 1'b0;
                        write <= 1'b0;
                        pc    <= pc_inc;
                        state <= RUN;
                    end
                end
                HALT: state <= HALT;
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_core_mc.sv
// tb_seq_core_mc: directed test-plan sequence plus random programs checked against an
// instruction-level reference model of seq_core_mc.
module tb_seq_core_mc;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] pc;
    logic [15:0]   instruction;
    logic          read, write, halted;
    logic [AW-1:0] address;
    logic [DW-1:0] data_out;
    logic [DW-1:0] data_in = '0;
    logic          mem_ready = 1'b0;

    logic [15:0] prog [1024];
    logic        ovr_en = 1'b0;
    logic [15:0] ovr_ins = '0;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_r [8];
    logic          m_mem, m_halt, m_read, m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_dout;
    logic [2:0]    m_dst;

    always #5 clk = ~clk;

    assign instruction = ovr_en ? ovr_ins : prog[pc];

    seq_core_mc #(.A_SIZE(AW), .D_SIZE(DW)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
        .read(read), .write(write), .address(address), .data_out(data_out),
        .data_in(data_in), .mem_ready(mem_ready), .halted(halted)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one instruction, straight from the ISA description.
    task automatic exec(input logic [15:0] ins);
        logic [DW-1:0] a, b, d;
        logic [63:0]   wide;
        longint        sd;
        int            amt, t;
        logic [2:0]    c;
        bit            taken;
        logic [AW-1:0] nxt;
        a = m_r[ins[5:3]];
        b = m_r[ins[2:0]];
        d = m_r[ins[8:6]];
        sd = longint'($signed(d));
        amt = int'(ins[5:0]);
        nxt = m_pc + 1'b1;
        case (ins[15:9])
            7'd1, 7'd2: m_r[ins[8:6]] = a + b;
            7'd3, 7'd4: m_r[ins[8:6]] = a - b;
            7'd5:       m_r[ins[8:6]] = a & b;
            7'd6:       m_r[ins[8:6]] = a | b;
            7'd7:       m_r[ins[8:6]] = a ^ b;
            7'd8:       m_r[ins[8:6]] = ~(a & b);
            7'd9:       m_r[ins[8:6]] = ~(a | b);
            7'd10:      m_r[ins[8:6]] = ~(a ^ b);
            7'd11:      m_r[ins[8:6]] = amt >= DW ? '0 : d >> amt;
            7'd12: begin
                wide = 64'(sd >>> amt);
                m_r[ins[8:6]] = wide[DW-1:0];
            end
            7'd13, 7'd14: m_r[ins[8:6]] = amt >= DW ? '0 : d << amt;
            7'd15: begin
                m_halt = 1'b1;
                return;
            end
`ifdef SEQ_CORE_MC_MUL_EN
            7'b0011100: m_r[ins[8:6]] = a * b;
`endif
            default: ;
        endcase
        if (ins[15:11] == 5'b00101) m_r[ins[10:8]][7:0] = ins[7:0];
        if (ins[15:11] == 5'b00100) begin
            m_mem = 1'b1; m_read = 1'b1; m_dst = ins[10:8]; m_addr = b[AW-1:0];
            return;
        end
        if (ins[15:11] == 5'b00110) begin
            m_mem = 1'b1; m_write = 1'b1; m_addr = m_r[ins[10:8]][AW-1:0]; m_dout = b;
            return;
        end
        c = ins[11:9];
        taken = (c == 3'd0 && sd < 0) || (c == 3'd1 && sd >= 0) || (c == 3'd2 && d == 0) || (c == 3'd3 && d != 0);
        t = int'(m_pc) + int'($signed(ins[5:0]));
        if (ins[15:12] == 4'b1000 || (ins[15:12] == 4'b1010 && taken)) nxt = b[AW-1:0];
        if (ins[15:12] == 4'b1100 || (ins[15:12] == 4'b1110 && taken)) nxt = t[AW-1:0];
        m_pc = nxt;
    endtask

    task automatic model_step(input bit rv, input bit rdy, input logic [DW-1:0] din, input logic [15:0] ins);
        if (!rv) begin
            m_pc = '0; m_mem = 0; m_halt = 0; m_read = 0; m_write = 0;
            m_addr = '0; m_dout = '0; m_dst = '0;
            for (int i = 0; i < 8; i++) m_r[i] = '0;
        end else if (m_halt) begin
        end else if (m_mem) begin
            if (rdy) begin
                if (m_read) m_r[m_dst] = din;
                m_read = 0; m_write = 0; m_mem = 0;
                m_pc = m_pc + 1'b1;
            end
        end else exec(ins);
    endtask

    task automatic step(input bit rv, input bit rdy, input logic [DW-1:0] din);
        rst = rv;
        mem_ready = rdy;
        data_in = din;
        model_step(rv, rdy, din, ovr_en ? ovr_ins : prog[m_pc]);
        @(posedge clk);
        #1;
        check("pc", pc, m_pc);
        check("read", read, m_read);
        check("write", write, m_write);
        check("address", address, m_addr);
        check("data_out", data_out, m_dout);
        check("halted", halted, m_halt);
        check("rw_excl", read & write, 0);
        for (int i = 0; i < 8; i++) check($sformatf("r%0d", i), dut.regs[i], m_r[i]);
    endtask

    function automatic logic [15:0] gen_ins();
        logic [15:0] w;
        w = 16'($urandom);
        case ($urandom_range(0, 9))
            0, 1, 2: w[15:9] = 7'($urandom_range(1, 14));
            3:       w[15:11] = 5'b00101;
            4:       w[15:11] = 5'b00100;
            5:       w[15:11] = 5'b00110;
            6:       w[15:9] = 7'b0011100;
            7:       w[15:14] = 2'b01;
            8:       w[15] = 1'b1;
            default: w[15:11] = 5'b00101;
        endcase
        if (w[15:9] == 7'b0001111) w[15:9] = 7'b0000000;
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) prog[i] = 16'h0000;
        prog[0]  = {5'b00101, 3'd1, 8'h05};
        prog[1]  = {5'b00101, 3'd2, 8'h03};
        prog[2]  = {7'b0000001, 3'd3, 3'd1, 3'd2};
        prog[3]  = {7'b0000011, 3'd4, 3'd2, 3'd1};
        prog[4]  = {5'b00110, 3'd1, 5'd0, 3'd3};
        prog[5]  = {5'b00100, 3'd5, 5'd0, 3'd2};
        prog[6]  = {4'b1100, 6'd0, 6'd4};
        prog[8]  = {4'b1100, 6'd0, 6'd3};
        prog[10] = {4'b1110, 3'd0, 3'd4, 6'h3E};
        prog[11] = {4'b1110, 3'd1, 3'd4, 6'h3E};
        prog[12] = {7'b0001111, 9'd0};

        step(0, 0, '0);
        check("rst_pc", pc, 0);
        check("rst_read", read, 0);
        check("rst_halted", halted, 0);
        repeat (4) step(1, 1, '0);
        check("tp_pc4", pc, 4);
        check("tp_r3", dut.regs[3], 8);
        check("tp_r4", dut.regs[4], 32'hFFFF_FFFE);

        for (int k = 0; k < 4; k++) begin
            step(1, 0, '0);
            check("tp_st_write", write, 1);
            check("tp_st_addr", address, 5);
            check("tp_st_data", data_out, 8);
            check("tp_st_pc", pc, 4);
        end
        step(1, 1, '0);
        check("tp_st_done", write, 0);
        check("tp_st_pc5", pc, 5);

        step(1, 0, '0);
        check("tp_ld_read", read, 1);
        check("tp_ld_addr", address, 3);
        step(1, 1, 32'hDEAD_BEEF);
        check("tp_ld_drop", read, 0);
        check("tp_ld_r5", dut.regs[5], 32'hDEAD_BEEF);
        check("tp_ld_pc", pc, 6);

        step(1, 1, '0);
        check("tp_jmpr", pc, 10);
        step(1, 1, '0);
        check("tp_jmprc_n", pc, 8);
        step(1, 1, '0);
        check("tp_jmpr2", pc, 11);
        step(1, 1, '0);
        check("tp_jmprc_nn", pc, 12);
        step(1, 1, '0);
        check("tp_halted", halted, 1);
        ovr_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ovr_ins = 16'($urandom);
            step(1, 1'($urandom), $urandom);
            check("tp_halt_pc", pc, 12);
            check("tp_halt_flag", halted, 1);
        end
        ovr_en = 1'b0;

        step(0, 1, '0);
        check("tp_halt_rst", halted, 0);
        repeat (4) step(1, 1, '0);
        step(1, 0, '0);
        step(1, 1, '0);
        step(1, 0, '0);
        step(1, 0, '0);
        check("tp_ldw_read", read, 1);
        step(0, 1, 32'hDEAD_BEEF);
        check("tp_mrst_read", read, 0);
        check("tp_mrst_pc", pc, 0);
        check("tp_mrst_r5", dut.regs[5], 0);
        check("tp_mrst_r3", dut.regs[3], 0);

        for (int i = 0; i < 1024; i++) prog[i] = gen_ins();
        step(0, 1, '0);
        for (int k = 0; k < 4000; k++)
            step($urandom_range(0, 299) != 0, $urandom_range(0, 2) != 0, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
